// File: rtl/sseg_scan_decoder.sv
// Seven-segment bus monitor: filters each strobed (AN, sseg) pair for stability,
// decodes the cathodes back to hex nibbles and checks digits arrive in scan order 0..3.
//
// state | meaning
// WAIT0 | waiting for digit 0 to start a frame
// GOT0  | digit 0 captured, expecting digit 1
// GOT1  | digits 0,1 captured, expecting digit 2
// GOT2  | digits 0..2 captured, expecting digit 3
module sseg_scan_decoder #(
    parameter int unsigned MIN_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  AN,
    input  logic [7:0]  sseg,
    output logic [15:0] dig,
    output logic [3:0]  dig_vld,
    output logic        frame_done,
    output logic        code_err,
    output logic        bus_err,
    output logic        seq_err
);

    localparam logic [7:0] HOLD = 8'(MIN_HOLD);

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        GOT0  = 2'd1,
        GOT1  = 2'd2,
        GOT2  = 2'd3
    } state_t;

    state_t      state;
    logic [11:0] in_q;
    logic [7:0]  run;
    logic        cap_pend;

    logic [11:0] pair_now;
    logic        differ;
    logic [7:0]  run_nxt;
    logic        cap_next;
    logic [3:0]  cap_an;
    logic [7:0]  cap_seg;
    logic        an_blank;
    logic        an_single;
    logic [1:0]  an_idx;
    logic [4:0]  dec;
    logic [1:0]  exp_idx;

    // Exact-match cathode table; bit 4 of the result flags a legal code.
    function automatic logic [4:0] decode(input logic [7:0] code);
        case (code)
            8'h81:   return {1'b1, 4'h0};
            8'hF3:   return {1'b1, 4'h1};
            8'h49:   return {1'b1, 4'h2};
            8'h61:   return {1'b1, 4'h3};
            8'h33:   return {1'b1, 4'h4};
            8'h25:   return {1'b1, 4'h5};
            8'h05:   return {1'b1, 4'h6};
            8'hF1:   return {1'b1, 4'h7};
            8'h01:   return {1'b1, 4'h8};
            8'h31:   return {1'b1, 4'h9};
            8'h11:   return {1'b1, 4'hA};
            8'h07:   return {1'b1, 4'hB};
            8'h8D:   return {1'b1, 4'hC};
            8'h43:   return {1'b1, 4'hD};
            8'h0D:   return {1'b1, 4'hE};
            8'h1D:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    // A capture fires on the one edge where the run first reaches MIN_HOLD;
    // the extra term stops a saturated run at 255 from re-firing.
    always_comb begin
        pair_now = {AN, sseg};
        differ   = (pair_now != in_q);
        if (differ)
            run_nxt = 8'd1;
        else if (run == 8'hFF)
            run_nxt = run;
        else
            run_nxt = run + 8'd1;
        cap_next = (run_nxt == HOLD) && (differ || (run != HOLD));
    end

    always_comb begin
        cap_an    = in_q[11:8];
        cap_seg   = in_q[7:0];
        an_blank  = 1'b0;
        an_single = 1'b0;
        an_idx    = 2'd0;
        case (cap_an)
            4'b1111: an_blank = 1'b1;
            4'b1110: begin an_single = 1'b1; an_idx = 2'd0; end
            4'b1101: begin an_single = 1'b1; an_idx = 2'd1; end
            4'b1011: begin an_single = 1'b1; an_idx = 2'd2; end
            4'b0111: begin an_single = 1'b1; an_idx = 2'd3; end
            default: ;
        endcase
        dec     = decode(cap_seg);
        exp_idx = 2'(state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q       <= {4'b1111, 8'hFF};
            run        <= 8'd0;
            cap_pend   <= 1'b0;
            state      <= WAIT0;
            dig        <= 16'h0000;
            dig_vld    <= 4'b0000;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
            bus_err    <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            in_q       <= pair_now;
            run        <= run_nxt;
            cap_pend   <= cap_next;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
            bus_err    <= 1'b0;
            seq_err    <= 1'b0;

            if (cap_pend && !an_blank) begin
                if (!an_single) begin
                    bus_err <= 1'b1;
                    state   <= WAIT0;
                end else if (!dec[4]) begin
                    code_err        <= 1'b1;
                    dig_vld[an_idx] <= 1'b0;
                    state           <= WAIT0;
                end else begin
                    dig[{an_idx, 2'b00} +: 4] <= dec[3:0];
                    dig_vld[an_idx]           <= 1'b1;
                    if (an_idx == exp_idx) begin
                        case (state)
                            WAIT0: state <= GOT0;
                            GOT0:  state <= GOT1;
                            GOT1:  state <= GOT2;
                            GOT2: begin
                                frame_done <= 1'b1;
                                state      <= WAIT0;
                            end
                            default: state <= WAIT0;
                        endcase
                    end else begin
                        // A stray digit 0 can still begin a new frame.
                        seq_err <= 1'b1;
                        state   <= (an_idx == 2'd0) ? GOT0 : WAIT0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: one instance at MIN_HOLD=1 for scan/order/error
// scenarios and one at MIN_HOLD=3 for the stability filter.
module tb_sseg_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an1, an3;
    logic [7:0]  sg1, sg3;
    logic [15:0] dig1, dig3;
    logic [3:0]  vld1, vld3;
    logic        fd1, ce1, be1, se1;
    logic        fd3, ce3, be3, se3;
    logic [3:0]  pulses1, pulses3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] scan_code [4] = '{8'h61, 8'h25, 8'h01, 8'h81};

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_FD   = 4'b1000;
    localparam logic [3:0] P_CE   = 4'b0100;
    localparam logic [3:0] P_BE   = 4'b0010;
    localparam logic [3:0] P_SE   = 4'b0001;

    always #5 clk = ~clk;

    assign pulses1 = {fd1, ce1, be1, se1};
    assign pulses3 = {fd3, ce3, be3, se3};

    sseg_scan_decoder #(.MIN_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .AN(an1), .sseg(sg1),
        .dig(dig1), .dig_vld(vld1),
        .frame_done(fd1), .code_err(ce1), .bus_err(be1), .seq_err(se1)
    );

    sseg_scan_decoder #(.MIN_HOLD(3)) dut3 (
        .clk(clk), .reset(reset), .AN(an3), .sseg(sg3),
        .dig(dig3), .dig_vld(vld3),
        .frame_done(fd3), .code_err(ce3), .bus_err(be3), .seq_err(se3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next edge.
    task automatic step1(input logic [3:0] a, input logic [7:0] s);
        an1 = a;
        sg1 = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [3:0] a, input logic [7:0] s);
        an3 = a;
        sg3 = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        an1 = 4'hF; sg1 = 8'hFF;
        an3 = 4'hF; sg3 = 8'hFF;
        #12;
        chk("rst_dig1", dig1, 16'h0000);
        chk("rst_vld1", 16'(vld1), 16'h0);
        chk("rst_pulses1", 16'(pulses1), 16'(P_NONE));
        chk("rst_dig3", dig3, 16'h0000);
        chk("rst_vld3", 16'(vld3), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full scan at one digit per clock
        for (int s = 1; s <= 13; s++) begin
            int d;
            d = (s - 1) % 4;
            step1(~(4'b0001 << d), scan_code[d]);
            chk("scan_pulses", 16'(pulses1),
                16'((s >= 5 && ((s - 5) % 4) == 0) ? P_FD : P_NONE));
        end
        chk("scan_dig", dig1, 16'h0853);
        chk("scan_vld", 16'(vld1), 16'hF);

        // Illegal code mid-frame
        step1(4'b1101, 8'h13);
        chk("ill_d0", 16'(pulses1), 16'(P_NONE));
        step1(4'b1011, 8'h01);
        chk("ill_code_err", 16'(pulses1), 16'(P_CE));
        chk("ill_vld", 16'(vld1), 16'b1101);
        chk("ill_dig", dig1, 16'h0853);
        step1(4'b0111, 8'h81);
        chk("ill_seq2", 16'(pulses1), 16'(P_SE));
        step1(4'b1111, 8'hFF);
        chk("ill_seq3", 16'(pulses1), 16'(P_SE));
        chk("ill_vld2", 16'(vld1), 16'b1101);
        step1(4'b1111, 8'hFF);
        chk("ill_quiet", 16'(pulses1), 16'(P_NONE));

        // Fresh frame 0..3
        step1(4'b1110, 8'h81); chk("fr_a", 16'(pulses1), 16'(P_NONE));
        step1(4'b1101, 8'hF3); chk("fr_b", 16'(pulses1), 16'(P_NONE));
        step1(4'b1011, 8'h49); chk("fr_c", 16'(pulses1), 16'(P_NONE));
        step1(4'b0111, 8'h61); chk("fr_d", 16'(pulses1), 16'(P_NONE));
        step1(4'b1111, 8'hFF); chk("fr_done", 16'(pulses1), 16'(P_FD));
        chk("fr_dig", dig1, 16'h3210);
        chk("fr_vld", 16'(vld1), 16'hF);

        // Bus fault, then a long blank
        step1(4'b1100, 8'h81); chk("bus_pre", 16'(pulses1), 16'(P_NONE));
        step1(4'b1111, 8'hFF); chk("bus_err", 16'(pulses1), 16'(P_BE));
        chk("bus_dig", dig1, 16'h3210);
        for (int i = 0; i < 10; i++) begin
            step1(4'b1111, 8'hFF);
            chk("blank_quiet", 16'(pulses1), 16'(P_NONE));
        end
        chk("blank_dig", dig1, 16'h3210);
        chk("blank_vld", 16'(vld1), 16'hF);

        // Order check: 0 then 2
        step1(4'b1110, 8'h81); chk("ord_a", 16'(pulses1), 16'(P_NONE));
        step1(4'b1011, 8'h49); chk("ord_b", 16'(pulses1), 16'(P_NONE));
        step1(4'b1111, 8'hFF); chk("ord_seq", 16'(pulses1), 16'(P_SE));
        step1(4'b1110, 8'h81); chk("ord_f0", 16'(pulses1), 16'(P_NONE));
        step1(4'b1101, 8'hF3); chk("ord_f1", 16'(pulses1), 16'(P_NONE));
        step1(4'b1011, 8'h49); chk("ord_f2", 16'(pulses1), 16'(P_NONE));
        step1(4'b0111, 8'h61); chk("ord_f3", 16'(pulses1), 16'(P_NONE));
        step1(4'b1111, 8'hFF); chk("ord_done", 16'(pulses1), 16'(P_FD));

        // Reset mid-frame, asserted between edges
        step1(4'b1110, 8'h81);
        step1(4'b1101, 8'hF3);
        step1(4'b1111, 8'hFF); chk("mid_pre", 16'(pulses1), 16'(P_NONE));
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_dig", dig1, 16'h0000);
        chk("mid_rst_vld", 16'(vld1), 16'h0);
        chk("mid_rst_pulses", 16'(pulses1), 16'(P_NONE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        step1(4'b1011, 8'h49); chk("mid_a", 16'(pulses1), 16'(P_NONE));
        step1(4'b0111, 8'h61); chk("mid_seq2", 16'(pulses1), 16'(P_SE));
        step1(4'b1111, 8'hFF); chk("mid_seq3", 16'(pulses1), 16'(P_SE));
        step1(4'b1110, 8'h81); chk("mid_f0", 16'(pulses1), 16'(P_NONE));
        step1(4'b1101, 8'hF3); chk("mid_f1", 16'(pulses1), 16'(P_NONE));
        step1(4'b1011, 8'h49); chk("mid_f2", 16'(pulses1), 16'(P_NONE));
        step1(4'b0111, 8'h61); chk("mid_f3", 16'(pulses1), 16'(P_NONE));
        step1(4'b1111, 8'hFF); chk("mid_done", 16'(pulses1), 16'(P_FD));
        chk("mid_dig", dig1, 16'h3210);

        // Hold filter, MIN_HOLD=3: a 2-edge hold is rejected
        for (int j = 0; j < 2; j++) begin
            step3(4'b1110, 8'h81);
            chk("h2_vld", 16'(vld3), 16'h0);
        end
        for (int j = 0; j < 3; j++) begin
            step3(4'b1111, 8'hFF);
            chk("h2_blank_vld", 16'(vld3), 16'h0);
            chk("h2_blank_pulses", 16'(pulses3), 16'(P_NONE));
        end
        // A 5-edge hold captures once, visible at edge k+3
        for (int j = 1; j <= 5; j++) begin
            step3(4'b1110, 8'h81);
            chk("h5_vld", 16'(vld3), 16'((j >= 4) ? 4'b0001 : 4'b0000));
            chk("h5_pulses", 16'(pulses3), 16'(P_NONE));
        end
        for (int j = 0; j < 4; j++) begin
            step3(4'b1111, 8'hFF);
            chk("h5_tail_pulses", 16'(pulses3), 16'(P_NONE));
            chk("h5_tail_vld", 16'(vld3), 16'h1);
        end
        chk("h5_dig", dig3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
